// File: rtl/swap_exchange_unit_pkg.sv
// ---------------------------------------------------------------------------
// swap_exchange_unit_pkg
// Shared definitions for the swap/exchange register bank:
//   - command opcodes (OP_WRITE, OP_SWAP, OP_READ, OP_ROTATE)
//   - control FSM state encoding (IDLE, EXEC, RESP)
//   - swap counter width and its saturating increment helper
// ---------------------------------------------------------------------------
package swap_exchange_unit_pkg;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SWAP   = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_ROTATE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int SWAP_CNT_W = 16;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [SWAP_CNT_W-1:0] sat_inc(input logic [SWAP_CNT_W-1:0] v);
        logic [SWAP_CNT_W-1:0] res;
        if (v == {SWAP_CNT_W{1'b1}}) begin
            res = v;
        end else begin
            res = v + {{(SWAP_CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/swap_exchange_unit_xchg_regbank.sv
// ---------------------------------------------------------------------------
// xchg_regbank
// DEPTH x WIDTH storage for the swap/exchange unit. All updates read the
// pre-edge contents, so a swap or rotate moves every affected word in a
// single edge with no partially-updated intermediate state.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears all entries)
//   i_we            : write i_wdata into entry i_idx_a
//   i_swap_en       : exchange entries i_idx_a and i_idx_b
//   i_rot_en        : rotate the bank up by one (last entry wraps to 0)
//   i_idx_a/i_idx_b : entry indices
//   i_wdata         : write data
//   o_entries       : all entries, flattened (entry i at bits [i*WIDTH +: WIDTH])
// Only one enable is expected per cycle; priority is rotate > swap > write.
// ---------------------------------------------------------------------------
module xchg_regbank
    import swap_exchange_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_we,
    input  logic                   i_swap_en,
    input  logic                   i_rot_en,
    input  logic [IW-1:0]          i_idx_a,
    input  logic [IW-1:0]          i_idx_b,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [DEPTH*WIDTH-1:0] o_entries
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Bank storage: clear on reset, otherwise apply at most one operation per edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_rot_en) begin
            r_mem[0] <= r_mem[DEPTH-1];
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end else if (i_swap_en) begin
            // Non-blocking pair: both sides see old values; a == b leaves the entry as is.
            r_mem[i_idx_a] <= r_mem[i_idx_b];
            r_mem[i_idx_b] <= r_mem[i_idx_a];
        end else if (i_we) begin
            r_mem[i_idx_a] <= i_wdata;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_flat
            assign o_entries[g*WIDTH +: WIDTH] = r_mem[g];
        end
    endgenerate

endmodule

// File: rtl/swap_exchange_unit.sv
// ---------------------------------------------------------------------------
// swap_exchange_unit
// Command-driven register bank supporting WRITE, READ, atomic two-entry SWAP
// and full-bank ROTATE. One command is accepted in IDLE, executed in EXEC and
// answered in RESP (held until the consumer takes it).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   cmd_valid     : command present         cmd_ready : unit accepts a command
//   cmd_op        : 00 WRITE 01 SWAP 10 READ 11 ROTATE
//   cmd_idx_a/b   : entry indices (b used by SWAP only)
//   cmd_data      : write data (WRITE only)
//   rsp_valid     : response present        rsp_ready : consumer takes it
//   rsp_data      : response payload
//   swap_count    : saturating count of executed SWAPs
// ---------------------------------------------------------------------------
module swap_exchange_unit
    import swap_exchange_unit_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [IW-1:0]         cmd_idx_a,
    input  logic [IW-1:0]         cmd_idx_b,
    input  logic [WIDTH-1:0]      cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [SWAP_CNT_W-1:0] swap_count
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_accept;
    logic                    w_cmd_ready;

    logic [1:0]              r_op;
    logic [IW-1:0]           r_idx_a;
    logic [IW-1:0]           r_idx_b;
    logic [WIDTH-1:0]        r_data;

    logic                    w_exec;
    logic                    w_we;
    logic                    w_swap_en;
    logic                    w_rot_en;

    logic [DEPTH*WIDTH-1:0]  w_entries;
    logic [WIDTH-1:0]        w_bank [DEPTH];
    logic [WIDTH-1:0]        w_rsp_next;

    logic [WIDTH-1:0]        r_rsp_data;
    logic [SWAP_CNT_W-1:0]   r_swap_count;

    // Ready drops immediately during reset so nothing can be accepted on a reset edge.
    assign w_cmd_ready = (r_state == IDLE) && !rst;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and command-accept decode.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid && w_cmd_ready) begin
                    w_state_next = EXEC;
                    w_accept     = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            EXEC: begin
                w_state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = RESP;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Command capture: the cmd_* inputs are only looked at on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_WRITE;
            r_idx_a <= '0;
            r_idx_b <= '0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_op    <= cmd_op;
            r_idx_a <= cmd_idx_a;
            r_idx_b <= cmd_idx_b;
            r_data  <= cmd_data;
        end
    end

    // Bank operation enables, active only for the single EXEC cycle.
    always_comb begin
        w_exec    = (r_state == EXEC);
        w_we      = 1'b0;
        w_swap_en = 1'b0;
        w_rot_en  = 1'b0;
        if (w_exec) begin
            case (r_op)
                OP_WRITE:  w_we      = 1'b1;
                OP_SWAP:   w_swap_en = 1'b1;
                OP_ROTATE: w_rot_en  = 1'b1;
                OP_READ:   w_we      = 1'b0;
                default:   w_we      = 1'b0;
            endcase
        end else begin
            w_we = 1'b0;
        end
    end

    xchg_regbank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_swap_en (w_swap_en),
        .i_rot_en  (w_rot_en),
        .i_idx_a   (r_idx_a),
        .i_idx_b   (r_idx_b),
        .i_wdata   (r_data),
        .o_entries (w_entries)
    );

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_unpack
            assign w_bank[g] = w_entries[g*WIDTH +: WIDTH];
        end
    endgenerate

    // Response payload from pre-edge bank contents (SWAP reports old bank[a]).
    always_comb begin
        w_rsp_next = r_rsp_data;
        case (r_op)
            OP_WRITE:  w_rsp_next = r_data;
            OP_READ:   w_rsp_next = w_bank[r_idx_a];
            OP_SWAP:   w_rsp_next = w_bank[r_idx_a];
            OP_ROTATE: w_rsp_next = w_bank[DEPTH-1];
            default:   w_rsp_next = r_rsp_data;
        endcase
    end

    // Response register: loaded in EXEC, frozen through RESP and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data <= '0;
        end else if (w_exec) begin
            r_rsp_data <= w_rsp_next;
        end
    end

    // Saturating SWAP counter; a == b swaps count too.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_swap_count <= '0;
        end else if (w_swap_en) begin
            r_swap_count <= sat_inc(r_swap_count);
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_data   = r_rsp_data;
    assign swap_count = r_swap_count;

endmodule

// File: tb/tb_swap_exchange_unit.sv
module tb_swap_exchange_unit;

    localparam logic [1:0] T_WRITE  = 2'b00;
    localparam logic [1:0] T_SWAP   = 2'b01;
    localparam logic [1:0] T_READ   = 2'b10;
    localparam logic [1:0] T_ROTATE = 2'b11;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_idx_a;
    logic [1:0]  cmd_idx_b;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [15:0] swap_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  mb [4];
    int          mc;
    logic        chk_en;
    logic        exp_valid;
    logic        exp_ready;
    logic [7:0]  exp_data;
    logic [15:0] exp_count;
    logic [7:0]  got;

    swap_exchange_unit #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_idx_a  (cmd_idx_a),
        .cmd_idx_b  (cmd_idx_b),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .swap_count (swap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
            chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_ready});
            chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_data});
            chk("swap_count", {16'd0, swap_count}, {16'd0, exp_count});
        end
    end

    // Time bound
    initial begin
        #400000;
        $display("FAIL timeout expected=finish");
        $fatal(1, "timeout");
    end

    // Issue one command from IDLE (called at posedge+1). hold = extra RESP cycles with rsp_ready low.
    task automatic run_cmd(input logic [1:0] op, input int a, input int b,
                           input logic [7:0] d, input int hold, output logic [7:0] r);
        logic [7:0] e;
        logic [7:0] t;
        int         cnt;
        cnt = mc;
        case (op)
            T_WRITE: begin e = d; mb[a] = d; end
            T_READ:  begin e = mb[a]; end
            T_SWAP:  begin
                e = mb[a]; t = mb[b]; mb[b] = mb[a]; mb[a] = t;
                cnt = (mc >= 65535) ? 65535 : mc + 1;
            end
            default: begin
                e = mb[3]; t = mb[3];
                mb[3] = mb[2]; mb[2] = mb[1]; mb[1] = mb[0]; mb[0] = t;
            end
        endcase
        mc = cnt;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx_a = a[1:0];
        cmd_idx_b = b[1:0];
        cmd_data  = d;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;                      // E0: accepted
        // scramble inputs; the unit must ignore them while busy
        cmd_valid = 1'b1;
        cmd_op    = $urandom_range(0, 3);
        cmd_idx_a = $urandom_range(0, 3);
        cmd_idx_b = $urandom_range(0, 3);
        cmd_data  = $urandom_range(0, 255);
        exp_ready = 1'b0;
        exp_valid = 1'b0;
        @(posedge clk); #1;                      // E1: response visible
        exp_valid = 1'b1;
        exp_data  = e;
        exp_count = mc[15:0];
        r = rsp_data;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;                      // handshake edge
        exp_valid = 1'b0;
        exp_ready = 1'b1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_idx_a = 2'b00;
        cmd_idx_b = 2'b00; cmd_data = 8'h00; rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) mb[i] = 8'h00;
        mc = 0;
        exp_valid = 1'b0; exp_ready = 1'b0; exp_data = 8'h00; exp_count = 16'h0000;
        chk_en = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ready = 1'b1;
        @(posedge clk); #1;

        // Writes then reads
        run_cmd(T_WRITE, 0, 0, 8'h11, 0, got);
        chk("write_echo", {24'd0, got}, 32'h11);
        run_cmd(T_WRITE, 1, 0, 8'h22, 0, got);
        run_cmd(T_WRITE, 2, 0, 8'h33, 0, got);
        run_cmd(T_WRITE, 3, 0, 8'h44, 0, got);
        run_cmd(T_READ, 0, 0, 8'h00, 0, got); chk("read0", {24'd0, got}, 32'h11);
        run_cmd(T_READ, 1, 0, 8'h00, 0, got); chk("read1", {24'd0, got}, 32'h22);
        run_cmd(T_READ, 2, 0, 8'h00, 0, got); chk("read2", {24'd0, got}, 32'h33);
        run_cmd(T_READ, 3, 0, 8'h00, 0, got); chk("read3", {24'd0, got}, 32'h44);

        // SWAP 1,3
        run_cmd(T_SWAP, 1, 3, 8'h00, 0, got);
        chk("swap13_rsp", {24'd0, got}, 32'h22);
        chk("swap13_cnt", {16'd0, swap_count}, 32'h1);
        run_cmd(T_READ, 1, 0, 8'h00, 0, got); chk("swap13_b1", {24'd0, got}, 32'h44);
        run_cmd(T_READ, 3, 0, 8'h00, 0, got); chk("swap13_b3", {24'd0, got}, 32'h22);
        run_cmd(T_READ, 0, 0, 8'h00, 0, got); chk("swap13_b0", {24'd0, got}, 32'h11);

        // SWAP with a == b
        run_cmd(T_SWAP, 2, 2, 8'h00, 0, got);
        chk("swap22_rsp", {24'd0, got}, 32'h33);
        chk("swap22_cnt", {16'd0, swap_count}, 32'h2);
        run_cmd(T_READ, 2, 0, 8'h00, 0, got); chk("swap22_b2", {24'd0, got}, 32'h33);

        // Restore {11,22,33,44} and rotate
        run_cmd(T_SWAP, 3, 1, 8'h00, 0, got);
        chk("swap31_rsp", {24'd0, got}, 32'h22);
        run_cmd(T_ROTATE, 0, 0, 8'h00, 0, got);
        chk("rot_rsp", {24'd0, got}, 32'h44);
        run_cmd(T_READ, 0, 0, 8'h00, 0, got); chk("rot_b0", {24'd0, got}, 32'h44);
        run_cmd(T_READ, 1, 0, 8'h00, 0, got); chk("rot_b1", {24'd0, got}, 32'h11);
        run_cmd(T_READ, 2, 0, 8'h00, 0, got); chk("rot_b2", {24'd0, got}, 32'h22);
        run_cmd(T_READ, 3, 0, 8'h00, 0, got); chk("rot_b3", {24'd0, got}, 32'h33);

        // Backpressure: 5 cycles of rsp_ready low
        run_cmd(T_READ, 2, 0, 8'h00, 5, got);
        chk("hold_rsp", {24'd0, got}, 32'h22);

        // Reset while in RESP
        begin
            logic [7:0] e;
            e = mb[1];
            cmd_valid = 1'b1; cmd_op = T_READ; cmd_idx_a = 2'd1; rsp_ready = 1'b0;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            exp_ready = 1'b0;
            @(posedge clk); #1;
            exp_valid = 1'b1; exp_data = e;
            chk("prerst_rsp", {24'd0, rsp_data}, 32'h11);
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            for (int i = 0; i < 4; i++) mb[i] = 8'h00;
            mc = 0;
            exp_valid = 1'b0; exp_data = 8'h00; exp_count = 16'h0000; exp_ready = 1'b1;
            chk("rst_valid", {31'd0, rsp_valid}, 32'h0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            run_cmd(T_READ, i, 0, 8'h00, 0, got);
            chk("rst_bank", {24'd0, got}, 32'h0);
        end

        // Counter saturation from 0xFFFE
        force dut.r_swap_count = 16'hFFFE;
        exp_count = 16'hFFFE;
        mc = 65534;
        @(posedge clk); #1;
        release dut.r_swap_count;
        @(posedge clk); #1;
        run_cmd(T_SWAP, 0, 1, 8'h00, 0, got);
        chk("sat1", {16'd0, swap_count}, 32'hFFFF);
        run_cmd(T_SWAP, 2, 3, 8'h00, 0, got);
        run_cmd(T_SWAP, 0, 3, 8'h00, 0, got);
        chk("sat3", {16'd0, swap_count}, 32'hFFFF);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
